// File: rtl/speck_pkg.sv
// Shared definitions for the bit-serial SPECK round datapaths: state encoding,
// default rotation amounts per word width, and word rotate helpers.
package speck_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int ALPHA_N16  = 7;
    localparam int BETA_N16   = 2;
    localparam int ALPHA_WIDE = 8;
    localparam int BETA_WIDE  = 3;

    function automatic int default_alpha(input int n);
        return (n == 16) ? ALPHA_N16 : ALPHA_WIDE;
    endfunction

    function automatic int default_beta(input int n);
        return (n == 16) ? BETA_N16 : BETA_WIDE;
    endfunction

    // Rotations work on a 64-bit carrier; only the low n bits are meaningful.
    function automatic logic [63:0] width_mask(input int unsigned n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned r,
                                         input int unsigned n);
        logic [63:0] vm;
        vm = v & width_mask(n);
        return ((vm << r) | (vm >> (n - r))) & width_mask(n);
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned r,
                                         input int unsigned n);
        logic [63:0] vm;
        vm = v & width_mask(n);
        return ((vm >> r) | (vm << (n - r))) & width_mask(n);
    endfunction

endpackage

// File: rtl/speck_full_sub.sv
// One-bit full subtractor (a - b - bin), borrow built from AND terms and
// inversions so it mirrors the structure of the encrypt-side adder cell.
module speck_full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic t_nab;
    logic t_nabin;
    logic t_bbin;

    assign t_nab   = ~a & b;
    assign t_nabin = ~a & bin;
    assign t_bbin  = b & bin;

    assign diff = a ^ b ^ bin;
    assign bout = ~(~t_nab & ~t_nabin & ~t_bbin);

endmodule

// File: rtl/speck_inv_round_serial.sv
// Bit-serial SPECK inverse round: subtracts LSB first, one bit per clock.
// Define SPECK_BORROW_FLAG_EN to expose the final borrow as borrow_flag.
module speck_inv_round_serial
    import speck_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int ALPHA  = default_alpha(WORD_W),
    parameter int BETA   = default_beta(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] x_in,
    input  logic [WORD_W-1:0] y_in,
    input  logic [WORD_W-1:0] k_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] x_out,
    output logic [WORD_W-1:0] y_out
`ifdef SPECK_BORROW_FLAG_EN
    ,
    output logic              borrow_flag
`endif
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WORD_W-1:0] a_reg;
    logic [WORD_W-1:0] b_reg;
    logic              borrow_reg;
    logic              diff_bit;
    logic              bout_bit;
    logic [WORD_W-1:0] y_rot;

    speck_full_sub u_sub (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow_reg),
        .diff (diff_bit),
        .bout (bout_bit)
    );

    assign y_rot = WORD_W'(rotr(64'(x_in ^ y_in), BETA, WORD_W));
    assign busy  = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SUB;
            SUB:     if (cnt_reg == CNT_LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            done       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
`ifdef SPECK_BORROW_FLAG_EN
            borrow_flag <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            done      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= x_in ^ k_in;
                        b_reg      <= y_rot;
                        y_out      <= y_rot;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                    end
                end
                SUB: begin
                    // A doubles as the result register: difference bits enter at the top.
                    a_reg      <= {diff_bit, a_reg[WORD_W-1:1]};
                    b_reg      <= {1'b0, b_reg[WORD_W-1:1]};
                    borrow_reg <= bout_bit;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                end
                FIN: begin
                    x_out <= WORD_W'(rotl(64'(a_reg), ALPHA, WORD_W));
                    done  <= 1'b1;
`ifdef SPECK_BORROW_FLAG_EN
                    borrow_flag <= borrow_reg;
`else
                    // Final borrow is the mod 2^n wrap and is simply dropped.
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
